// File: rtl/icache_ctrl_pkg.sv
// rtl/icache_ctrl_pkg.sv - shared cache geometry constants and controller state encoding
package icache_ctrl_pkg;

  // Instruction word width and cache block geometry
  localparam int IWORD_BITS           = 32;
  localparam int IBLOCK_SIZE_BITS     = 128;
  localparam int ISET_INDEX_SIZE      = 6;
  localparam int ITAG_SIZE            = 22;
  localparam int IMEM_BLOCK_ADDR_SIZE = ITAG_SIZE + ISET_INDEX_SIZE;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ICTRL_IDLE   = 2'd0,
    ICTRL_REFILL = 2'd1,
    ICTRL_WRITE  = 2'd2,
    ICTRL_REPLAY = 2'd3
  } ictrl_state_e;

endpackage

// File: rtl/icache_refill_buf.sv
// rtl/icache_refill_buf.sv - refill beat counter and block assembly buffer
module icache_refill_buf #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int BEAT_W      = $clog2(BLOCK_WORDS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_beat_en,
  input  logic [WORD_W-1:0]             i_wdata,
  output logic [BEAT_W-1:0]             o_beat,
  output logic                          o_last_beat,
  output logic [BLOCK_WORDS*WORD_W-1:0] o_block
);

  logic [BEAT_W-1:0]             r_beat;
  logic [BLOCK_WORDS*WORD_W-1:0] r_block;
  logic [BLOCK_WORDS-1:0]        w_word_we;
  logic                          w_last;

  assign w_last      = (r_beat == BEAT_W'(BLOCK_WORDS - 1));
  assign o_beat      = r_beat;
  assign o_last_beat = w_last;
  assign o_block     = r_block;

  // One-hot write enable for the buffer word addressed by the current beat
  always_comb begin
    w_word_we = '0;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      w_word_we[k] = i_beat_en && (r_beat == BEAT_W'(k));
    end
  end

  // Beat counter: cleared at miss start, holds on the last beat until the next clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= '0;
    end else if (i_clear) begin
      r_beat <= '0;
    end else if (i_beat_en && !w_last) begin
      r_beat <= r_beat + BEAT_W'(1);
    end
  end

  // Capture each returned memory word into its slot, word 0 at the low bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_block <= '0;
    end else begin
      for (int k = 0; k < BLOCK_WORDS; k++) begin
        if (w_word_we[k]) begin
          r_block[k*WORD_W +: WORD_W] <= i_wdata;
        end
      end
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - instruction cache lookup, miss refill and replay sequencer
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = IBLOCK_SIZE_BITS / WORD_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_req,
  input  logic [ADDR_W-1:0]               fetch_addr,
  output logic                            fetch_stall,
  output logic                            fetch_valid,
  output logic [WORD_W-1:0]               fetch_instr,
  output logic                            sram_ren,
  output logic                            sram_wen,
  output logic [IMEM_BLOCK_ADDR_SIZE-1:0] sram_block_addr,
  output logic [IBLOCK_SIZE_BITS-1:0]     sram_wdata,
  input  logic                            sram_hit,
  input  logic [IBLOCK_SIZE_BITS-1:0]     sram_rdata,
  output logic                            mem_req,
  output logic [ADDR_W-1:0]               mem_addr,
  input  logic                            mem_ready,
  input  logic [WORD_W-1:0]               mem_rdata,
  output logic [31:0]                     miss_count
);

  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int OFF    = BEAT_W + 2;
  localparam int BLK_W  = IMEM_BLOCK_ADDR_SIZE;

  ictrl_state_e          r_state;
  ictrl_state_e          w_state_next;
  logic [BLK_W-1:0]      r_miss_blk;
  logic [BEAT_W-1:0]     r_miss_word;
  logic [31:0]           r_miss_count;

  logic [BLK_W-1:0]      w_fetch_blk;
  logic [BEAT_W-1:0]     w_fetch_word;
  logic                  w_miss;
  logic                  w_beat_en;
  logic [BEAT_W-1:0]     w_beat;
  logic                  w_last_beat;
  logic [IBLOCK_SIZE_BITS-1:0] w_block;
  logic                  w_unused_addr;

  assign w_fetch_blk   = fetch_addr[OFF+BLK_W-1:OFF];
  assign w_fetch_word  = fetch_addr[OFF-1:2];
  assign w_unused_addr = ^fetch_addr[1:0];

  assign w_miss    = (r_state == ICTRL_IDLE) && fetch_req && !sram_hit;
  assign w_beat_en = (r_state == ICTRL_REFILL) && mem_ready;

  assign mem_addr   = {r_miss_blk, w_beat, 2'b00};
  assign sram_wdata = w_block;
  assign miss_count = r_miss_count;

  icache_refill_buf #(
    .WORD_W      (WORD_W),
    .BLOCK_WORDS (BLOCK_WORDS),
    .BEAT_W      (BEAT_W)
  ) u_refill_buf (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_miss),
    .i_beat_en   (w_beat_en),
    .i_wdata     (mem_rdata),
    .o_beat      (w_beat),
    .o_last_beat (w_last_beat),
    .o_block     (w_block)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ICTRL_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch the missing address and count misses, saturating at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miss_blk   <= '0;
      r_miss_word  <= '0;
      r_miss_count <= '0;
    end else if (w_miss) begin
      r_miss_blk  <= w_fetch_blk;
      r_miss_word <= w_fetch_word;
      if (r_miss_count != 32'hFFFF_FFFF) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  // Next state plus lookup, refill and fetch-response decodes
  always_comb begin
    w_state_next    = r_state;
    sram_ren        = 1'b0;
    sram_wen        = 1'b0;
    sram_block_addr = r_miss_blk;
    fetch_stall     = 1'b0;
    fetch_valid     = 1'b0;
    fetch_instr     = '0;
    mem_req         = 1'b0;
    case (r_state)
      ICTRL_IDLE: begin
        sram_ren        = fetch_req;
        sram_block_addr = w_fetch_blk;
        if (fetch_req) begin
          if (sram_hit) begin
            fetch_valid = 1'b1;
            fetch_instr = sram_rdata[w_fetch_word*WORD_W +: WORD_W];
          end else begin
            fetch_stall  = 1'b1;
            w_state_next = ICTRL_REFILL;
          end
        end
      end
      ICTRL_REFILL: begin
        mem_req     = 1'b1;
        fetch_stall = 1'b1;
        if (mem_ready && w_last_beat) begin
          w_state_next = ICTRL_WRITE;
        end
      end
      ICTRL_WRITE: begin
        sram_wen     = 1'b1;
        fetch_stall  = 1'b1;
        w_state_next = ICTRL_REPLAY;
      end
      ICTRL_REPLAY: begin
        sram_ren     = 1'b1;
        fetch_valid  = fetch_req;
        fetch_instr  = w_block[r_miss_word*WORD_W +: WORD_W];
        w_state_next = ICTRL_IDLE;
      end
      default: begin
        w_state_next = ICTRL_IDLE;
      end
    endcase
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Sequencing controller for the parametrized instruction-cache SRAM array. Sits between the RISC-V fetch stage and the cache SRAM / instruction-memory port. It performs the lookup, stalls fetch on a miss, and fetches the missing block from memory one word per handshake. It then writes the block into the SRAM and replays the lookup so the fetch completes as a hit.

## Interface
Parameters:
- `ADDR_W`, 32, fetch byte-address width.
- `WORD_W`, 32, instruction and memory-bus word width.
- `BLOCK_WORDS`, `IBLOCK_SIZE_BITS`/`WORD_W`, words per cache block; power of two, ≥2.

Ports (clock and reset first):
- `clk` in 1: the single clock for the block.
- `rst` in 1: reset, asynchronous and active-low.
- `fetch_req` in 1: fetch stage requests the instruction at `fetch_addr`.
- `fetch_addr` in `ADDR_W`: byte address, word-aligned.
- `fetch_stall` out 1: fetch stage must hold `fetch_req` and `fetch_addr`.
- `fetch_valid` out 1: `fetch_instr` is valid this cycle.
- `fetch_instr` out `WORD_W`: returned instruction word.
- `sram_ren` out 1: SRAM lookup enable.
- `sram_wen` out 1: SRAM block-write enable.
- `sram_block_addr` out `IMEM_BLOCK_ADDR_SIZE`: {tag, index} sent to the SRAM.
- `sram_wdata` out `IBLOCK_SIZE_BITS`: block being refilled.
- `sram_hit` in 1: SRAM hit, combinational from `sram_ren` and the address.
- `sram_rdata` in `IBLOCK_SIZE_BITS`: SRAM read block, combinational.
- `mem_req` out 1: memory word-read request, held until accepted.
- `mem_addr` out `ADDR_W`: word address of the current beat.
- `mem_ready` in 1: memory returns `mem_rdata` and accepts the request this cycle.
- `mem_rdata` in `WORD_W`: returned memory word.
- `miss_count` out 32: saturating count of misses.

## Operation
- Address fields:
  - OFF = log2(`BLOCK_WORDS`)+2.
  - Block address = `fetch_addr`[OFF+`IMEM_BLOCK_ADDR_SIZE`-1:OFF].
  - Word select = `fetch_addr`[OFF-1:2].
- FSM states: IDLE, REFILL, WRITE, REPLAY.
- IDLE:
  - `sram_ren`=`fetch_req`; `sram_block_addr` comes from `fetch_addr`.
  - `fetch_req`&`sram_hit`: `fetch_valid`=1, `fetch_stall`=0, and `fetch_instr` = the selected word of `sram_rdata`. All of this is combinational, in the same cycle.
  - `fetch_req`&!`sram_hit`: `fetch_stall`=1. Latch the block address into `miss_blk`, clear `beat`, increment `miss_count` (saturating at 2^32-1), and go to REFILL.
- REFILL:
  - `mem_req`=1; `mem_addr`={`miss_blk`, `beat`, 2'b00}.
  - On `mem_ready`: store `mem_rdata` into buffer word `beat`, then `beat`++.
  - On `mem_ready` at the last beat, go to WRITE.
  - `sram_ren`=0 and `sram_wen`=0 throughout; `fetch_stall`=1.
- WRITE: for exactly one cycle, drive `sram_wen`=1, `sram_ren`=0, `sram_block_addr`=`miss_blk` and `sram_wdata`=buffer. The SRAM commits at this edge. Next state is REPLAY.
- REPLAY:
  - `sram_ren`=1 with `sram_block_addr` = the latched `miss_blk` address.
  - `fetch_stall` and `fetch_valid` behave as in IDLE, but `fetch_instr` is taken from the refill buffer (word select of the latched address). This does not depend on `sram_hit`.
  - Next state is IDLE.
- Buffer layout: word k occupies bits [k*`WORD_W` +: `WORD_W`]. Word 0 is the lowest address.
- Boundary conditions:
  - `fetch_req` dropped during REFILL: the refill is still completed and written. In REPLAY, `fetch_valid`=`fetch_req`.
  - `fetch_addr` changed during a stall is a protocol violation; the controller uses the latched address.
  - The `beat` counter wraps only via the state change, never by overflow.
  - A `mem_ready` arriving outside REFILL is ignored.

## Timing
- Reset values (`rst`=0, asynchronous):
  - State IDLE; `beat`, `miss_blk`, buffer and `miss_count` = 0.
  - With the buffer at 0, `mem_req`=0 and `sram_wen`=0.
  - `fetch_stall` and `fetch_valid` follow IDLE combinational rules.
- Reset mid-refill: the controller drops to IDLE immediately and `mem_req` deasserts asynchronously. No SRAM write occurs.
- Hit latency: 0 cycles (combinational).
- Miss latency, from the miss cycle to `fetch_valid`: 1 + Σ(per-beat memory wait) + `BLOCK_WORDS` + 1 (WRITE) cycles. With `mem_ready` tied high and 4 words this is 6 cycles; `fetch_valid` rises in the 6th cycle after the miss cycle.
- `sram_ren` and `sram_wen` are never both 1.
- All outputs other than the fetch result and the `sram_ren`/`sram_block_addr` lookup path are registered-state decodes.

## Structure
- `constants.vh` supplies `IBLOCK_SIZE_BITS`, `IMEM_BLOCK_ADDR_SIZE`, `ITAG_SIZE` and `ISET_INDEX_SIZE`.
- Add `IWORD_BITS` (32) and the FSM state encodings `ICTRL_IDLE`/`REFILL`/`WRITE`/`REPLAY` to `constants.vh`.
- One sub-module, `icache_refill_buf`: beat counter, word write-enable decode, block assembly and `last_beat` flag.
- The FSM, address muxing and miss counter stay in `icache_ctrl`.

## Test plan
- Cold miss, `BLOCK_WORDS`=4, `mem_ready`=1, fetch 0x100:
  - `mem_addr` sequence is 0x100, 0x104, 0x108, 0x10C.
  - One `sram_wen` pulse, then `fetch_valid` with the word from 0x100.
  - `miss_count`=1.
- Warm hit: re-fetch 0x104 → `fetch_valid` in the same cycle, word 1 of the block, no `mem_req`, `miss_count` unchanged.
- Memory wait states: `mem_ready` asserts every 3rd cycle → buffer contents are correct and total stall is 1+12+1 cycles.
- `fetch_req` dropped in beat 2 → refill completes, SRAM is written, `fetch_valid`=0 in REPLAY, and a later fetch of the same block hits.
- Assert `rst`=0 during beat 1 → `mem_req` falls immediately and there is no `sram_wen`. A refetch after reset misses again with `miss_count`=1.
- Two addresses with the same index and different tags, alternated → each access misses and refills. The expected instruction words are checked against a memory model.
